// File: rtl/data_mem_ctrl_if.sv
// Data-bus interface between the MEM-stage controller (master) and the data memory (slave).
interface data_mem_ctrl_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory access controller: turns loads/stores into a req/ack
// bus transaction, stalls the pipeline until ack, and registers the load word.
// Optional build macro MISALIGN_TRAP_EN: misaligned word/half accesses raise
// AddrErrM for one cycle instead of issuing a bus request.
// StoreTypeM carries the access size for loads as well as stores.
module data_mem_ctrl #(
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [1:0]      StoreTypeM,
  input  logic [31:0]     ALUOutM,
  input  logic [31:0]     WriteDataM,
  output logic [31:0]     ReadDataM,
  output logic            StallM,
  output logic            AddrErrM,
  data_mem_ctrl_if.master dbus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state, w_state_nxt;
  logic        r_req, w_req_nxt;
  logic        r_we, w_we_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [3:0]  r_be, w_be_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;

  logic        w_access;
  logic        w_misalign;
  logic        w_stall;
  logic [1:0]  w_a;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_access = MemReadM | MemWriteM;
  assign w_a      = ALUOutM[1:0];

  // Byte-lane enables and replicated store data for the access in MEM
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (MemWriteM) begin
      case (StoreTypeM)
        2'b01: begin
          w_be    = 4'b0011 << {w_a[1], 1'b0};
          w_wdata = {2{WriteDataM[15:0]}};
        end
        2'b10: begin
          w_be    = 4'b0001 << w_a;
          w_wdata = {4{WriteDataM[7:0]}};
        end
        default: w_wdata = WriteDataM;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Alignment check: word needs a==0, half needs a[0]==0, byte is always aligned
  always_comb begin
    w_misalign = 1'b0;
    case (StoreTypeM)
      2'b01:   w_misalign = w_a[0];
      2'b10:   w_misalign = 1'b0;
      default: w_misalign = (w_a != 2'b00);
    endcase
  end

  assign AddrErrM = ~rst & (r_state == S_IDLE) & w_access & w_misalign;
`else
  assign w_misalign = 1'b0;
  assign AddrErrM   = 1'b0;
`endif

  // Next-state and next-bus-register logic; stall is combinational from state
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_be_nxt    = r_be;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && !w_misalign) begin
          w_stall     = 1'b1;
          w_state_nxt = S_BUS;
          w_req_nxt   = 1'b1;
          w_we_nxt    = MemWriteM;
          w_addr_nxt  = {ALUOutM[31:2], 2'b00};
          w_be_nxt    = w_be;
          w_wdata_nxt = w_wdata;
        end
      end
      S_BUS: begin
        w_stall = 1'b1;
        if (dbus.dbus_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_DONE;
          if (!r_we) begin
            w_rdata_nxt = dbus.dbus_rdata;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and bus registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      r_rdata <= RESET_RDATA;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_be    <= w_be_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign StallM          = w_stall & ~rst;
  assign ReadDataM       = r_rdata;
  assign dbus.dbus_req   = r_req;
  assign dbus.dbus_we    = r_we;
  assign dbus.dbus_addr  = r_addr;
  assign dbus.dbus_be    = r_be;
  assign dbus.dbus_wdata = r_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: per-instruction transaction model producing a
// per-cycle expected trace, compared against the DUT on every falling edge.
module tb_data_mem_ctrl;

  typedef struct packed {
    logic        stall;
    logic        err;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        MemReadM;
  logic        MemWriteM;
  logic [1:0]  StoreTypeM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        AddrErrM;

  data_mem_ctrl_if dbus();

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .StoreTypeM (StoreTypeM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .AddrErrM   (AddrErrM),
    .dbus       (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t q[$];

  // model state: what the bus registers and load register must currently hold
  logic        m_we    = 1'b0;
  logic [31:0] m_addr  = 32'h0;
  logic [3:0]  m_be    = 4'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  int stall_run  = 0;
  int req_run    = 0;
  int last_stall = 0;
  int last_req   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic wr, input logic [1:0] st, input logic [31:0] addr);
    int lane;
    if (!wr) return 4'hF;
    if (st == 2'b01) return addr[1] ? 4'b1100 : 4'b0011;
    if (st == 2'b10) begin
      lane = int'(addr[1:0]);
      return 4'(1 << lane);
    end
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic wr, input logic [1:0] st, input logic [31:0] d);
    if (!wr) return 32'h0;
    if (st == 2'b01) return {16'h0, d[15:0]} * 32'h0001_0001;
    if (st == 2'b10) return {24'h0, d[7:0]} * 32'h0101_0101;
    return d;
  endfunction

  function automatic logic exp_trap(input logic [1:0] st, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
    if (st == 2'b01) return addr[0];
    if (st == 2'b10) return 1'b0;
    return addr[1:0] != 2'b00;
`else
    return 1'b0 & st[0] & addr[0];
`endif
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.stall = 1'b0;
    e.err   = 1'b0;
    e.req   = 1'b0;
    e.we    = m_we;
    e.addr  = m_addr;
    e.be    = m_be;
    e.wdata = m_wdata;
    e.rdata = m_rdata;
    return e;
  endfunction

  // one clock cycle: expectation queued for the falling edge inside this cycle
  task automatic step(input exp_t e, input logic ack, input logic [31:0] rd);
    dbus.dbus_ack   = ack;
    dbus.dbus_rdata = rd;
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // one instruction through MEM; lat = BUS cycle in which the slave acks
  task automatic issue(input logic rd, input logic wr, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int lat, input logic [31:0] rdat);
    exp_t e;
    MemReadM   = rd;
    MemWriteM  = wr;
    StoreTypeM = st;
    ALUOutM    = addr;
    WriteDataM = wd;
    e = cur_exp();
    if (!rd && !wr) begin
      step(e, 1'($urandom), $urandom);
      return;
    end
    if (exp_trap(st, addr)) begin
      e.err = 1'b1;
      step(e, 1'($urandom), $urandom);
      return;
    end
    e.stall = 1'b1;
    step(e, 1'($urandom), $urandom);
    m_we    = wr;
    m_addr  = {addr[31:2], 2'b00};
    m_be    = exp_be(wr, st, addr);
    m_wdata = exp_wdata(wr, st, wd);
    for (int k = 1; k <= lat; k++) begin
      e = cur_exp();
      e.stall = 1'b1;
      e.req   = 1'b1;
      step(e, k == lat, (k == lat) ? rdat : $urandom);
    end
    if (!wr) m_rdata = rdat;
    e = cur_exp();
    step(e, 1'($urandom), $urandom);
  endtask

  task automatic reset_mid_bus();
    exp_t e;
    MemReadM   = 1'b1;
    MemWriteM  = 1'b0;
    StoreTypeM = 2'b00;
    ALUOutM    = 32'h40;
    WriteDataM = 32'h0;
    e = cur_exp();
    e.stall = 1'b1;
    step(e, 1'b0, $urandom);
    m_we = 1'b0; m_addr = 32'h40; m_be = 4'hF; m_wdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      e = cur_exp();
      e.stall = 1'b1;
      e.req   = 1'b1;
      step(e, 1'b0, $urandom);
    end
    rst = 1'b1;
    #1;
    chk("rst_bus_req", 32'(dbus.dbus_req), 32'h0);
    chk("rst_bus_stall", 32'(StallM), 32'h0);
    chk("rst_bus_rdata", ReadDataM, 32'h0);
    m_we = 1'b0; m_addr = 32'h0; m_be = 4'h0; m_wdata = 32'h0; m_rdata = 32'h0;
    e = cur_exp();
    step(e, 1'b1, $urandom);
    step(e, 1'b0, $urandom);
    rst = 1'b0;
  endtask

  // per-cycle compare against the model trace, plus stall/req run lengths
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.stall = StallM;
      a.err   = AddrErrM;
      a.req   = dbus.dbus_req;
      a.we    = dbus.dbus_we;
      a.addr  = dbus.dbus_addr;
      a.be    = dbus.dbus_be;
      a.wdata = dbus.dbus_wdata;
      a.rdata = ReadDataM;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle%0d actual stall=%b err=%b req=%b we=%b addr=%h be=%h wdata=%h rdata=%h required stall=%b err=%b req=%b we=%b addr=%h be=%h wdata=%h rdata=%h",
                 cyc, a.stall, a.err, a.req, a.we, a.addr, a.be, a.wdata, a.rdata,
                 e.stall, e.err, e.req, e.we, e.addr, e.be, e.wdata, e.rdata);
      end
    end
    if (StallM === 1'b1) stall_run++;
    else if (stall_run != 0) begin
      last_stall = stall_run;
      stall_run  = 0;
    end
    if (dbus.dbus_req === 1'b1) req_run++;
    else if (req_run != 0) begin
      last_req = req_run;
      req_run  = 0;
    end
  end

  initial begin
    exp_t e;
    int kind;
    rst             = 1'b1;
    MemReadM        = 1'b0;
    MemWriteM       = 1'b0;
    StoreTypeM      = 2'b00;
    ALUOutM         = 32'h0;
    WriteDataM      = 32'h0;
    dbus.dbus_ack   = 1'b0;
    dbus.dbus_rdata = 32'h0;
    @(posedge clk);
    #1;

    // reset state
    chk("reset_req", 32'(dbus.dbus_req), 32'h0);
    chk("reset_stall", 32'(StallM), 32'h0);
    chk("reset_rdata", ReadDataM, 32'h0);
    chk("reset_be", 32'(dbus.dbus_be), 32'h0);
    e = cur_exp();
    step(e, 1'b0, 32'h0);
    step(e, 1'b1, 32'h0);
    rst = 1'b0;
    issue(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1, 32'h0);

    // model pins against hand-computed values
    chk("pin_be_sb103", 32'(exp_be(1'b1, 2'b10, 32'h103)), 32'h8);
    chk("pin_wd_sb", exp_wdata(1'b1, 2'b10, 32'h0000_00AB), 32'hABAB_ABAB);
    chk("pin_be_sh42", 32'(exp_be(1'b1, 2'b01, 32'h42)), 32'hC);
    chk("pin_wd_sh", exp_wdata(1'b1, 2'b01, 32'h0000_0042), 32'h0042_0042);

    // sw, ack in third BUS cycle
    issue(1'b0, 1'b1, 2'b00, 32'h100, 32'hDEAD_BEEF, 3, $urandom);
    chk("sw_stall_cycles", 32'(last_stall), 32'd4);
    chk("sw_req_cycles", 32'(last_req), 32'd3);

    // sb, ack in first BUS cycle
    issue(1'b0, 1'b1, 2'b10, 32'h103, 32'h0000_00AB, 1, $urandom);
    chk("sb_stall_cycles", 32'(last_stall), 32'd2);
    chk("sb_be", 32'(dbus.dbus_be), 32'h8);
    chk("sb_addr", dbus.dbus_addr, 32'h100);

    // lw then ALU instructions
    issue(1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 2, 32'h1234_5678);
    chk("lw_rdata", ReadDataM, 32'h1234_5678);
    issue(1'b0, 1'b0, 2'b00, $urandom, $urandom, 1, 32'h0);
    issue(1'b0, 1'b0, 2'b00, $urandom, $urandom, 1, 32'h0);
    chk("lw_rdata_held", ReadDataM, 32'h1234_5678);

    // lw then sh back-to-back
    issue(1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 1, 32'h0BAD_F00D);
    issue(1'b0, 1'b1, 2'b01, 32'h42, 32'h0000_0042, 2, $urandom);
    chk("sh_be", 32'(dbus.dbus_be), 32'hC);
    chk("sh_wdata", dbus.dbus_wdata, 32'h0042_0042);
    chk("sh_keeps_rdata", ReadDataM, 32'h0BAD_F00D);

    // reset while in BUS, then a clean load
    reset_mid_bus();
    issue(1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 2, 32'h55AA_55AA);
    chk("post_rst_lw", ReadDataM, 32'h55AA_55AA);

    // misaligned word load
    issue(1'b1, 1'b0, 2'b00, 32'h21, 32'h0, 2, 32'hCAFE_0001);
`ifdef MISALIGN_TRAP_EN
    chk("mis_no_load", ReadDataM, 32'h55AA_55AA);
    chk("mis_addr_kept", dbus.dbus_addr, 32'h40);
`else
    chk("mis_addr", dbus.dbus_addr, 32'h20);
    chk("mis_be", 32'(dbus.dbus_be), 32'hF);
`endif

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      issue(kind == 1 || kind == 3, kind == 2 || kind == 3, 2'($urandom),
            $urandom, $urandom, $urandom_range(1, 5), $urandom);
    end
    issue(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns MemReadM/MemWriteM into a req/ack transaction on the external data bus. Builds byte enables and replicated write data for sb/sh/sw.
- Stalls the pipeline until the bus acknowledges, then presents the raw load word as ReadDataM.
- Load byte/half extraction is not done here; the WB stage does it using LoadTypeW and ALUOutW[1:0].

Parameters:
- RESET_RDATA, 32'h0, value ReadDataM takes on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- MemReadM  in  1  load in MEM stage.
- MemWriteM  in  1  store in MEM stage; wins if both are set.
- StoreTypeM  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- ALUOutM  in  32  effective byte address.
- WriteDataM  in  32  store data, right-aligned.
- ReadDataM  out  32  registered full word from the last completed load.
- StallM  out  1  freeze IF/ID/EX/MEM registers and bubble MEM/WB.
- AddrErrM  out  1  misaligned access flag (see Optional Feature).
- dbus_req  out  1  bus request, registered.
- dbus_we  out  1  1 write, 0 read.
- dbus_addr  out  32  {ALUOutM[31:2],2'b00}.
- dbus_be  out  4  byte enables.
- dbus_wdata  out  32  replicated store data.
- dbus_ack  in  1  slave completes the transfer in this cycle.
- dbus_rdata  in  32  read data, valid when dbus_ack=1.

Behaviour:
- Reset (async, immediate) clears all of the following:
  - state=IDLE
  - dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata = 0
  - ReadDataM=RESET_RDATA
  - StallM=0, AddrErrM=0
- FSM states are IDLE, BUS and DONE.
- IDLE:
  - If access = MemReadM|MemWriteM: StallM=1 combinationally.
  - On the next edge: latch dbus_* from the inputs, set dbus_req=1, go to BUS.
  - Otherwise stay in IDLE with StallM=0.
- BUS:
  - dbus_req and all dbus_* outputs are held stable; StallM=1.
  - On a cycle with dbus_ack=1:
    - ReadDataM<=dbus_rdata for reads; unchanged for writes.
    - dbus_req<=0.
    - Go to DONE.
  - No timeout: the controller waits indefinitely for dbus_ack.
- DONE:
  - StallM=0, so the pipeline advances past the serviced instruction.
  - Next state is always IDLE. This prevents re-issuing the same access.
  - The following instruction is evaluated in IDLE on the next cycle.
- Stall count = 1 + number of BUS cycles. Minimum is 2, when ack arrives in the first BUS cycle.
- dbus_ack is ignored in IDLE and DONE.
- Byte enables and write data (a = ALUOutM[1:0]):
  - Word: be=1111, wdata=WriteDataM.
  - Half: be=0011<<(2*a[1]), wdata={2{WriteDataM[15:0]}}.
  - Byte: be=0001<<a, wdata={4{WriteDataM[7:0]}}.
  - Loads: be=1111, wdata=0.
- ReadDataM changes only on load completion; it is held through non-load instructions and stores.
- Reset asserted during BUS: dbus_req drops in the same cycle (async), the transaction is abandoned, and StallM=0.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - In IDLE, a word access with a!=0, or a half access with a[0]=1, does not enter BUS.
  - AddrErrM=1 combinationally, StallM=0, no bus request. The pulse lasts one cycle while the instruction passes MEM.
- Not defined:
  - AddrErrM is tied to 0.
  - Word accesses ignore a; half accesses ignore a[0] (use a[1] only).

Test Plan:
- sw 0xDEADBEEF @0x100, ack 3 cycles after req -> dbus_req high 3 cycles, addr 0x100, be 1111, we 1; StallM high 4 cycles; low in DONE.
- sb 0x000000AB @0x103, ack in first BUS cycle -> be 1000, wdata 0xABABABAB, addr 0x100; StallM high exactly 2 cycles.
- lw @0x20, ack with rdata 0x12345678 -> ReadDataM=0x12345678 in DONE cycle; held through following ALU instructions.
- lw @0x20 then sh 0x00000042 @0x42, back-to-back -> second req starts 1 cycle after DONE, be 1100, wdata 0x00420042; ReadDataM unchanged by the sh.
- rst pulsed while in BUS -> dbus_req=0 and StallM=0 immediately, ReadDataM=0; next lw restarts cleanly from IDLE.
- With MISALIGN_TRAP_EN, lw @0x21 -> AddrErrM=1 for 1 cycle, dbus_req never asserted, StallM=0. Without it, the same lw issues addr 0x20, be 1111.
